register4: RTL and testbench



---
 rtl/register4_pkg.sv | 13 +
 rtl/register4_chk.sv | 16 +
 rtl/register4_parity.sv | 30 +++
 rtl/register4.sv | 112 +++++++++++
 tb/tb_register4.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/register4_pkg.sv
// register4_pkg
// Shared constants and types for the register4 storage element.
//   REG4_WIDTH : default data width (4 bits)
//   REG4_RESET : default reset value for a REG4_WIDTH register
//   reg4_t     : logic vector of REG4_WIDTH bits
package register4_pkg;

  localparam int REG4_WIDTH = 4;
  localparam logic [REG4_WIDTH-1:0] REG4_RESET = 4'b0000;

  typedef logic [REG4_WIDTH-1:0] reg4_t;

endpackage : register4_pkg

// File: rtl/register4_chk.sv
// register4_chk
// Simulation-only protocol checks for register4.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   we    : write enable, must never be X/Z at a rising edge out of reset
module register4_chk (
  input logic clk,
  input logic reset,
  input logic we
);

  // A write enable of unknown value at a capturing edge is an environment error.
  we_known_a : assert property (@(posedge clk) disable iff (reset) !$isunknown(we));

endmodule : register4_chk

// File: rtl/register4_parity.sv
// register4_parity
// Even-parity generator and compare for the register4 stored value.
// Only instantiated when REGISTER4_PARITY_EN is defined.
// Ports:
//   data_i   : value about to be captured (parity is generated from it)
//   stored_i : value currently held in the storage flops
//   par_i    : parity bit currently held alongside stored_i
//   par_o    : even parity (XOR-reduce) of data_i
//   err_o    : high when stored_i and par_i disagree
module register4_parity
  import register4_pkg::*;
#(
  parameter int WIDTH = REG4_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] stored_i,
  input  logic             par_i,
  output logic             par_o,
  output logic             err_o
);

  // Even parity of an arbitrary-width vector.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  assign par_o = even_parity(data_i);
  assign err_o = (even_parity(stored_i) != par_i);

endmodule : register4_parity

// File: rtl/register4.sv
// register4
// Write-enabled storage register with asynchronous active-high clear and
// a "written since reset" status flag.
// Configuration macro: REGISTER4_PARITY_EN adds q_par / par_err.
// Parameters:
//   WIDTH       : data width, 1..64
//   RESET_VALUE : value held in q while reset is asserted
// Ports:
//   clk     : system clock, rising-edge active
//   reset   : asynchronous active-high reset
//   we      : write enable
//   d       : write data
//   q       : stored value, driven straight from flops
//   written : high once any write has occurred since the last reset
//   q_par   : (parity build) registered even parity of q
//   par_err : (parity build) combinational mismatch between ^q and q_par
module register4
  import register4_pkg::*;
#(
  parameter int               WIDTH       = REG4_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
`ifdef REGISTER4_PARITY_EN
  output logic             q_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] q,
  output logic             written
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic             written_d;
  logic             written_q;

  // Next-state selection: capture on write, otherwise hold.
  always_comb begin
    q_d       = q_q;
    written_d = written_q;
    if (we) begin
      q_d       = d;
      written_d = 1'b1;
    end else begin
      q_d       = q_q;
      written_d = written_q;
    end
  end

  // Storage flops; reset clears immediately and dominates any write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q       <= RESET_VALUE;
      written_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      written_q <= written_d;
    end
  end

  assign q       = q_q;
  assign written = written_q;

`ifdef REGISTER4_PARITY_EN
  localparam logic PAR_RESET = ^RESET_VALUE;

  logic par_gen_s;
  logic par_d;
  logic par_q;

  register4_parity #(
    .WIDTH (WIDTH)
  ) u_parity (
    .data_i   (d),
    .stored_i (q_q),
    .par_i    (par_q),
    .par_o    (par_gen_s),
    .err_o    (par_err)
  );

  // Parity is generated from d so it lands on the same edge as q.
  always_comb begin
    par_d = par_q;
    if (we) begin
      par_d = par_gen_s;
    end else begin
      par_d = par_q;
    end
  end

  // Parity flop, reset to the parity of RESET_VALUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= PAR_RESET;
    end else begin
      par_q <= par_d;
    end
  end

  assign q_par = par_q;
`endif

  register4_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .we    (we)
  );

endmodule : register4

// File: tb/tb_register4.sv
// tb_register4
// Directed-vector bench for register4 with a queue-based scoreboard:
// stimulus pushes the hand-computed expected state, a monitor pops and
// compares against the DUT outputs at the moment of the push.
module tb_register4;

  logic       clk;
  logic       reset;
  logic       we;
  logic [3:0] d;
  logic [3:0] q;
  logic       written;
`ifdef REGISTER4_PARITY_EN
  logic       q_par;
  logic       par_err;
`endif

  typedef struct {
    logic [3:0] q;
    logic       written;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   stim_done;

  register4 #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .d       (d),
`ifdef REGISTER4_PARITY_EN
    .q_par   (q_par),
    .par_err (par_err),
`endif
    .q       (q),
    .written (written)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record an expectation; the monitor samples the DUT immediately.
  task automatic expect_state(input logic [3:0] eq, input logic ew, input string nm);
    exp_t e;
    e.q       = eq;
    e.written = ew;
    e.name    = nm;
    exp_q.push_back(e);
    #1;
  endtask

  // Drive one vector at the falling edge, then sample 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic w, input logic [3:0] dv,
                       input logic [3:0] eq, input logic ew, input string nm);
    @(negedge clk);
    reset = r;
    we    = w;
    d     = dv;
    @(posedge clk);
    #1;
    expect_state(eq, ew, nm);
  endtask

  // Monitor: compare every expectation against the DUT as it is pushed.
  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    forever begin
      wait (exp_q.size() > 0);
      e = exp_q.pop_front();
      checks++;
      if (q !== e.q) begin
        errors++;
        $display("FAIL %s q: got %b expected %b", e.name, q, e.q);
      end
      checks++;
      if (written !== e.written) begin
        errors++;
        $display("FAIL %s written: got %b expected %b", e.name, written, e.written);
      end
`ifdef REGISTER4_PARITY_EN
      checks++;
      if (q_par !== ^e.q) begin
        errors++;
        $display("FAIL %s q_par: got %b expected %b", e.name, q_par, ^e.q);
      end
      checks++;
      if (par_err !== 1'b0) begin
        errors++;
        $display("FAIL %s par_err: got %b expected 0", e.name, par_err);
      end
`endif
    end
  end

  initial begin
    stim_done = 1'b0;
    reset = 1'b1;
    we    = 1'b0;
    d     = 4'b0000;
    #2;
    expect_state(4'b0000, 1'b0, "reset_immediate");
    @(posedge clk);
    #1;
    expect_state(4'b0000, 1'b0, "reset_held_edge");

    cycle(1'b0, 1'b0, 4'b1010, 4'b0000, 1'b0, "hold_no_write");
    cycle(1'b0, 1'b1, 4'b1010, 4'b1010, 1'b1, "write_1010");
    cycle(1'b0, 1'b0, 4'b1111, 4'b1010, 1'b1, "hold_vs_1111");
    cycle(1'b0, 1'b0, 4'b0000, 4'b1010, 1'b1, "hold_vs_0000");
    cycle(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b1, "write_0011");
    cycle(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b1, "rewrite_0011");

    // Asynchronous reset between edges.
    @(negedge clk);
    we = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    expect_state(4'b0000, 1'b0, "async_reset_midcycle");

    cycle(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, "reset_dominates_we");
    cycle(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, "reset_we_low");
    cycle(1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, "release_no_write");
    cycle(1'b0, 1'b1, 4'b0111, 4'b0111, 1'b1, "write_0111_odd");
    cycle(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1, "write_1000");
    cycle(1'b0, 1'b0, 4'b0101, 4'b1000, 1'b1, "hold_vs_0101");
    cycle(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, "write_zero_keeps_written");
    stim_done = 1'b1;
  end

  // End of run: bounded drain of the scoreboard, then the summary.
  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 100) begin
      #1;
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_register4
